// File: rtl/layer_axis_bridge_pkg.sv
// Shared types and helpers for the AXI-Stream bridge around a CNN layer core.
package layer_axis_bridge_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DRAIN = 2'd3
  } bridge_state_e;

  localparam int DEF_IN_COUNT  = 64;
  localparam int DEF_OUT_COUNT = 10;
  localparam int DEF_DATA_SIZE = 16;

  // Address width for a buffer of the given depth (never narrower than one bit).
  function automatic int adr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_axis_bridge_if.sv
// AXI-Stream channel (data, valid, last, ready) with producer/consumer modports.
interface layer_axis_bridge_if
  import layer_axis_bridge_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE
);

  logic [DATA_SIZE-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/layer_axis_bridge_buf_ram.sv
// Frame buffer: one synchronous write port, one asynchronous read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module layer_axis_bridge_buf_ram
  import layer_axis_bridge_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  localparam int ADR_W    = adr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADR_W-1:0]     wr_adr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADR_W-1:0]     rd_adr,
  output logic [DATA_SIZE-1:0] rd_data
);

  localparam logic [ADR_W:0] DEPTH_C = (ADR_W + 1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic                 wr_ok_s;
  logic                 rd_ok_s;

  assign wr_ok_s = wr_en && ({1'b0, wr_adr} < DEPTH_C);
  assign rd_ok_s = ({1'b0, rd_adr} < DEPTH_C);

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_adr] <= wr_data;
    end
  end

  // Read port, zero when addressed past the end.
  always_comb begin
    rd_data = '0;
    if (rd_ok_s) begin
      rd_data = mem_r[rd_adr];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/layer_axis_bridge.sv
// AXI-Stream front/back end for one layer core: fill input buffer, start core,
// capture core writes, then stream the output buffer once the core is done.
module layer_axis_bridge
  import layer_axis_bridge_pkg::*;
#(
  parameter int IN_COUNT   = DEF_IN_COUNT,
  parameter int OUT_COUNT  = DEF_OUT_COUNT,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  localparam int IN_ADR_W  = adr_w(IN_COUNT),
  localparam int OUT_ADR_W = adr_w(OUT_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  layer_axis_bridge_if.slave    s_axis,
  layer_axis_bridge_if.master   m_axis,
  output logic                  axisif_start,
  input  logic                  axisif_done,
  input  logic [IN_ADR_W-1:0]   axisif_bufferIn_adr,
  output logic [DATA_SIZE-1:0]  axisif_bufferIn_data,
  input  logic [OUT_ADR_W-1:0]  axisif_bufferOut_adr,
  input  logic [DATA_SIZE-1:0]  axisif_bufferOut_data,
  input  logic                  axisif_bufferOut_wr,
  output logic                  frame_err
);

  localparam logic [IN_ADR_W-1:0]  IN_LAST  = IN_ADR_W'(IN_COUNT - 1);
  localparam logic [OUT_ADR_W-1:0] OUT_LAST = OUT_ADR_W'(OUT_COUNT - 1);

  bridge_state_e          state_r;
  bridge_state_e          state_s;
  logic [IN_ADR_W-1:0]    wr_cnt_r;
  logic [OUT_ADR_W-1:0]   rd_cnt_r;
  logic                   frame_err_r;
  logic                   in_beat_s;
  logic                   in_full_s;
  logic                   in_short_s;
  logic                   out_beat_s;
  logic                   out_end_s;
  logic                   done_s;
  logic [DATA_SIZE-1:0]   out_rd_data_s;

  // A beat at the final slot completes the frame even without tlast.
  assign in_beat_s  = (state_r == S_FILL) && s_axis.tvalid;
  assign in_full_s  = in_beat_s && (wr_cnt_r == IN_LAST);
  assign in_short_s = in_beat_s && s_axis.tlast && (wr_cnt_r != IN_LAST);
  assign out_beat_s = (state_r == S_DRAIN) && m_axis.tready;
  assign out_end_s  = out_beat_s && (rd_cnt_r == OUT_LAST);
  assign done_s     = (state_r == S_BUSY) && axisif_done;

  layer_axis_bridge_buf_ram #(.DEPTH(IN_COUNT), .DATA_SIZE(DATA_SIZE)) u_inbuf (
    .clk     (clk),
    .wr_en   (in_beat_s),
    .wr_adr  (wr_cnt_r),
    .wr_data (s_axis.tdata),
    .rd_adr  (axisif_bufferIn_adr),
    .rd_data (axisif_bufferIn_data)
  );

  layer_axis_bridge_buf_ram #(.DEPTH(OUT_COUNT), .DATA_SIZE(DATA_SIZE)) u_outbuf (
    .clk     (clk),
    .wr_en   (axisif_bufferOut_wr),
    .wr_adr  (axisif_bufferOut_adr),
    .wr_data (axisif_bufferOut_data),
    .rd_adr  (rd_cnt_r),
    .rd_data (out_rd_data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; done outside BUSY is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_FILL:  if (in_full_s) state_s = S_START; else state_s = S_FILL;
      S_START: state_s = S_BUSY;
      S_BUSY:  if (done_s) state_s = S_DRAIN; else state_s = S_BUSY;
      S_DRAIN: if (out_end_s) state_s = S_FILL; else state_s = S_DRAIN;
      default: state_s = S_FILL;
    endcase
  end

  // Frame counters and sticky framing error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_r    <= '0;
      rd_cnt_r    <= '0;
      frame_err_r <= 1'b0;
    end else begin
      if (in_full_s || in_short_s) begin
        wr_cnt_r <= '0;
      end else if (in_beat_s) begin
        wr_cnt_r <= wr_cnt_r + IN_ADR_W'(1);
      end
      if (done_s || out_end_s) begin
        rd_cnt_r <= '0;
      end else if (out_beat_s) begin
        rd_cnt_r <= rd_cnt_r + OUT_ADR_W'(1);
      end
      if (in_short_s || (in_full_s && !s_axis.tlast)) begin
        frame_err_r <= 1'b1;
      end
    end
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    axisif_start  = 1'b0;
    case (state_r)
      S_FILL:  s_axis.tready = 1'b1;
      S_START: axisif_start  = 1'b1;
      S_BUSY:  axisif_start  = 1'b0;
      S_DRAIN: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = (rd_cnt_r == OUT_LAST);
      end
      default: s_axis.tready = 1'b0;
    endcase
  end

  assign m_axis.tdata = out_rd_data_s;
  assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_layer_axis_bridge.sv
// Directed/randomized bench for layer_axis_bridge with a queue-based frame model
// and a core model that reads the input buffer and writes the output buffer.
module tb_layer_axis_bridge;

  localparam int IN_N  = 64;
  localparam int OUT_N = 10;
  localparam int DW    = 16;

  logic          clk;
  logic          rst;
  logic          axisif_start;
  logic          axisif_done;
  logic [5:0]    in_adr;
  logic [DW-1:0] in_data;
  logic [3:0]    out_adr;
  logic [DW-1:0] out_data;
  logic          out_wr;
  logic          frame_err;

  layer_axis_bridge_if #(.DATA_SIZE(DW)) s_axis ();
  layer_axis_bridge_if #(.DATA_SIZE(DW)) m_axis ();

  layer_axis_bridge #(.IN_COUNT(IN_N), .OUT_COUNT(OUT_N), .DATA_SIZE(DW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .s_axis                (s_axis),
    .m_axis                (m_axis),
    .axisif_start          (axisif_start),
    .axisif_done           (axisif_done),
    .axisif_bufferIn_adr   (in_adr),
    .axisif_bufferIn_data  (in_data),
    .axisif_bufferOut_adr  (out_adr),
    .axisif_bufferOut_data (out_data),
    .axisif_bufferOut_wr   (out_wr),
    .frame_err             (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            start_cnt = 0;
  int            hs_cnt    = 0;
  int            model_starts = 0;
  logic          model_err = 1'b0;
  logic [DW-1:0] beat_q [$];
  logic [DW-1:0] in_model [IN_N];
  logic [DW-1:0] exp_out [OUT_N];

  // Event monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && axisif_start) start_cnt++;
    if (!rst && m_axis.tvalid && m_axis.tready) hs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends n beats; tlast on index last_at (-1: never). Model applies the framing rules.
  task automatic send_frame(input int n, input int last_at, input bit rnd);
    logic [DW-1:0] d;
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = rnd ? DW'($urandom) : DW'(i + 1);
      s_axis.tdata  = d;
      s_axis.tvalid = 1'b1;
      s_axis.tlast  = (i == last_at);
      check("s_tready_fill", s_axis.tready, 32'd1);
      beat_q.push_back(d);
      acc = 1'b0;
      if (beat_q.size() == IN_N) begin
        acc = 1'b1;
        if (i != last_at) model_err = 1'b1;
        for (int k = 0; k < IN_N; k++) in_model[k] = beat_q[k];
        beat_q.delete();
        model_starts++;
      end else if (i == last_at) begin
        model_err = 1'b1;
        beat_q.delete();
      end
      tick();
      check("start_after_beat", axisif_start, 32'(acc));
      check("frame_err", frame_err, 32'(model_err));
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    if (acc) begin
      tick();
      check("start_single_cycle", axisif_start, 32'd0);
      check("s_tready_busy", s_axis.tready, 32'd0);
    end else begin
      check("s_tready_after_short", s_axis.tready, 32'd1);
    end
    check("start_count", 32'(start_cnt), 32'(model_starts));
  endtask

  task automatic core_read(input int a);
    in_adr = 6'(a);
    #1;
    check("bufin_read", in_data, 32'(in_model[a]));
    tick();
  endtask

  task automatic core_write(input bit rnd);
    for (int i = 0; i < OUT_N; i++) begin
      out_wr   = 1'b1;
      out_adr  = 4'(i);
      out_data = rnd ? DW'($urandom) : DW'(i * 3);
      exp_out[i] = out_data;
      tick();
    end
    for (int a = OUT_N; a < 16; a++) begin
      out_wr   = 1'b1;
      out_adr  = 4'(a);
      out_data = 16'hBAD0 | DW'(a);
      tick();
    end
    out_wr = 1'b0;
  endtask

  task automatic done_and_drain(input bit toggle);
    int idx;
    int cyc;
    int h0;
    idx = 0;
    cyc = 0;
    check("tvalid_busy", m_axis.tvalid, 32'd0);
    axisif_done = 1'b1;
    tick();
    axisif_done = 1'b0;
    check("tvalid_after_done", m_axis.tvalid, 32'd1);
    h0 = hs_cnt;
    while (idx < OUT_N && cyc < 200) begin
      m_axis.tready = toggle ? (cyc % 2 == 0) : 1'b1;
      check("m_tvalid", m_axis.tvalid, 32'd1);
      check("m_tdata", m_axis.tdata, 32'(exp_out[idx]));
      check("m_tlast", m_axis.tlast, 32'(idx == OUT_N - 1));
      if (m_axis.tready) idx++;
      tick();
      cyc++;
    end
    m_axis.tready = 1'b0;
    check("drain_words", 32'(idx), 32'(OUT_N));
    check("drain_handshakes", 32'(hs_cnt - h0), 32'(OUT_N));
    check("s_tready_after_drain", s_axis.tready, 32'd1);
    check("m_tvalid_after_drain", m_axis.tvalid, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    axisif_done = 1'b0;
    in_adr = 6'd0;
    out_adr = 4'd0;
    out_data = 16'd0;
    out_wr = 1'b0;
    s_axis.tdata = 16'd0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    m_axis.tready = 1'b0;
    repeat (3) tick();
    check("rst_s_tready", s_axis.tready, 32'd1);
    check("rst_m_tvalid", m_axis.tvalid, 32'd0);
    check("rst_m_tlast", m_axis.tlast, 32'd0);
    check("rst_start", axisif_start, 32'd0);
    check("rst_frame_err", frame_err, 32'd0);
    rst = 1'b0;

    // 1: counting frame, start pulse, core reads
    send_frame(IN_N, IN_N - 1, 1'b0);
    in_adr = 6'd5;
    #1;
    check("bufin_adr5", in_data, 32'd6);
    tick();
    core_read(0);
    core_read(IN_N - 1);

    // 2: out[i] = 3i, plain drain
    core_write(1'b0);
    done_and_drain(1'b0);

    // 3: random frame, stalled drain
    send_frame(IN_N, IN_N - 1, 1'b1);
    core_read(int'($urandom_range(0, IN_N - 1)));
    core_read(int'($urandom_range(0, IN_N - 1)));
    core_write(1'b1);
    done_and_drain(1'b1);

    // 4: short frame dropped, next frame normal, error sticky
    send_frame(20, 19, 1'b1);
    send_frame(IN_N, IN_N - 1, 1'b1);
    core_read(int'($urandom_range(0, IN_N - 1)));
    core_write(1'b1);
    done_and_drain(1'b0);
    check("frame_err_sticky", frame_err, 32'd1);

    // 5: missing tlast, then done during FILL ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_err = 1'b0;
    beat_q.delete();
    check("frame_err_cleared", frame_err, 32'd0);
    send_frame(IN_N, -1, 1'b1);
    core_write(1'b1);
    done_and_drain(1'b1);
    axisif_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_in_fill_tready", s_axis.tready, 32'd1);
      check("done_in_fill_tvalid", m_axis.tvalid, 32'd0);
    end
    axisif_done = 1'b0;
    send_frame(IN_N, IN_N - 1, 1'b1);
    core_write(1'b1);

    // 6: reset mid-drain at word 4, then a normal frame
    axisif_done = 1'b1;
    tick();
    axisif_done = 1'b0;
    m_axis.tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("pre_rst_tdata", m_axis.tdata, 32'(exp_out[k]));
      tick();
    end
    check("word4_tdata", m_axis.tdata, 32'(exp_out[4]));
    check("word4_tvalid", m_axis.tvalid, 32'd1);
    rst = 1'b1;
    m_axis.tready = 1'b0;
    tick();
    check("rst_drain_tvalid", m_axis.tvalid, 32'd0);
    check("rst_drain_tready", s_axis.tready, 32'd1);
    check("rst_drain_start", axisif_start, 32'd0);
    check("rst_drain_err", frame_err, 32'd0);
    rst = 1'b0;
    model_err = 1'b0;
    beat_q.delete();
    send_frame(IN_N, IN_N - 1, 1'b1);
    core_read(int'($urandom_range(0, IN_N - 1)));
    core_write(1'b1);
    done_and_drain(1'b0);
    check("final_frame_err", frame_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
